// File: rtl/demo_sequencer.sv
// One-hot demo selector: debounced next/prev buttons, switches applied only at frame start.
// Optional auto-advance timer is built only when DEMO_SEQ_AUTO_EN is defined.
module demo_sequencer #(
    parameter int unsigned P_STATES          = 4,
    parameter int unsigned P_DEBOUNCE_CYCLES = 250000,
    parameter int unsigned P_SETTLE_FRAMES   = 2,
    parameter int unsigned P_AUTO_CYCLES     = 250000000
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_btn_next,
    input  logic                i_btn_prev,
    input  logic                i_frame_start,
    output logic [P_STATES-1:0] o_state,
    output logic                o_switch,
    output logic                o_busy
);

    localparam int unsigned DB_W     = $clog2(P_DEBOUNCE_CYCLES + 1);
    localparam int unsigned SETTLE_W = (P_SETTLE_FRAMES > 0) ? $clog2(P_SETTLE_FRAMES + 1) : 1;

    if (P_STATES < 2) begin : g_states_check
        $error("demo_sequencer: P_STATES must be >= 2");
    end
    if (P_DEBOUNCE_CYCLES < 1 || P_AUTO_CYCLES < 1) begin : g_cycles_check
        $error("demo_sequencer: P_DEBOUNCE_CYCLES and P_AUTO_CYCLES must be >= 1");
    end

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        SETTLE  = 2'd2
    } fsm_t;

    // Button conditioning; index 0 = next, index 1 = prev
    logic [1:0]      btn_raw;
    logic [1:0]      sync1;
    logic [1:0]      sync2;
    logic [1:0]      db_lvl;
    logic [1:0]      db_lvl_d;
    logic [DB_W-1:0] db_cnt [2];
    logic [1:0]      btn_req_c;

    assign btn_raw   = {i_btn_prev, i_btn_next};
    assign btn_req_c = db_lvl & ~db_lvl_d;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sync1    <= '0;
            sync2    <= '0;
            db_lvl   <= '0;
            db_lvl_d <= '0;
            for (int i = 0; i < 2; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            sync1    <= btn_raw;
            sync2    <= sync1;
            db_lvl_d <= db_lvl;
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == db_lvl[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_W'(P_DEBOUNCE_CYCLES - 1)) begin
                    db_lvl[i] <= sync2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + DB_W'(1);
                end
            end
        end
    end

    // Coincident next/prev requests cancel each other
    logic req_next_c;
    logic req_prev_c;
    fsm_t fsm_q;
    fsm_t fsm_d;

`ifdef DEMO_SEQ_AUTO_EN
    localparam int unsigned AUTO_W = $clog2(P_AUTO_CYCLES + 1);

    logic [AUTO_W-1:0] auto_cnt;
    logic              auto_fire_c;

    // A button request in the same cycle takes priority over the timer
    assign auto_fire_c = (fsm_q == IDLE) && (btn_req_c == 2'b00) &&
                         (auto_cnt == AUTO_W'(P_AUTO_CYCLES - 1));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            auto_cnt <= '0;
        end else if ((fsm_q != IDLE) || (btn_req_c != 2'b00) || auto_fire_c) begin
            auto_cnt <= '0;
        end else begin
            auto_cnt <= auto_cnt + AUTO_W'(1);
        end
    end

    assign req_next_c = (btn_req_c[0] & ~btn_req_c[1]) | auto_fire_c;
`else
    assign req_next_c = btn_req_c[0] & ~btn_req_c[1];
`endif
    assign req_prev_c = btn_req_c[1] & ~btn_req_c[0];

    logic                dir_q;
    logic                dir_d;
    logic [SETTLE_W-1:0] settle_q;
    logic [SETTLE_W-1:0] settle_d;
    logic [P_STATES-1:0] state_d;
    logic                switch_d;
    logic                busy_d;

    // State register, including the registered outputs
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            fsm_q    <= IDLE;
            dir_q    <= 1'b0;
            settle_q <= '0;
            o_state  <= P_STATES'(1);
            o_switch <= 1'b0;
            o_busy   <= 1'b0;
        end else begin
            fsm_q    <= fsm_d;
            dir_q    <= dir_d;
            settle_q <= settle_d;
            o_state  <= state_d;
            o_switch <= switch_d;
            o_busy   <= busy_d;
        end
    end

    // Next-state logic; dir 0 = next, 1 = prev
    always_comb begin
        fsm_d    = fsm_q;
        dir_d    = dir_q;
        settle_d = settle_q;
        case (fsm_q)
            IDLE: begin
                if (req_next_c || req_prev_c) begin
                    fsm_d = PENDING;
                    dir_d = req_prev_c;
                end
            end
            PENDING: begin
                if (i_frame_start) begin
                    if (P_SETTLE_FRAMES == 0) begin
                        fsm_d = IDLE;
                    end else begin
                        fsm_d    = SETTLE;
                        settle_d = SETTLE_W'(P_SETTLE_FRAMES);
                    end
                end
            end
            SETTLE: begin
                if (i_frame_start) begin
                    settle_d = settle_q - SETTLE_W'(1);
                    if (settle_q <= SETTLE_W'(1)) begin
                        fsm_d = IDLE;
                    end
                end
            end
            default: begin
                fsm_d = IDLE;
            end
        endcase
    end

    // Output next values; rotation happens on the frame-start edge in PENDING
    always_comb begin
        state_d  = o_state;
        switch_d = 1'b0;
        busy_d   = (fsm_d != IDLE);
        if ((fsm_q == PENDING) && i_frame_start) begin
            switch_d = 1'b1;
            if (dir_q) begin
                state_d = {o_state[0], o_state[P_STATES-1:1]};
            end else begin
                state_d = {o_state[P_STATES-2:0], o_state[P_STATES-1]};
            end
        end
    end

endmodule

// File: tb/tb_demo_sequencer.sv
// Scoreboard bench for demo_sequencer: directed scenarios plus random button/frame traffic.
module tb_demo_sequencer;

    localparam int unsigned N    = 4;
    localparam int          NS   = 4;
    localparam int unsigned DB   = 4;
    localparam int unsigned SF   = 1;
    localparam int unsigned AUTO = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         bn = 1'b0;
    logic         bp = 1'b0;
    logic         fs = 1'b0;
    logic [N-1:0] st;
    logic         sw;
    logic         busy;

    int tests = 0;
    int fails = 0;

    // Reference model: active demo index, pending direction (+1/-1/0), settle frames left
    int m_idx    = 0;
    int m_pend   = 0;
    int m_settle = 0;
    logic [N-1:0] exp_q[$];
    logic [N-1:0] mon_exp;

    always #5 clk = ~clk;

    demo_sequencer #(
        .P_STATES          (N),
        .P_DEBOUNCE_CYCLES (DB),
        .P_SETTLE_FRAMES   (SF),
        .P_AUTO_CYCLES     (AUTO)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_btn_next    (bn),
        .i_btn_prev    (bp),
        .i_frame_start (fs),
        .o_state       (st),
        .o_switch      (sw),
        .o_busy        (busy)
    );

    function automatic logic [N-1:0] onehot(input int idx);
        logic [N-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every o_switch pulse must match the next queued expectation
    always @(negedge clk) begin
        if (!rst && sw) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL switch_unexpected: o_state=%b with no switch expected", st);
            end else begin
                mon_exp = exp_q.pop_front();
                if (st !== mon_exp) begin
                    fails++;
                    $display("FAIL switch_state: got %b expected %b", st, mon_exp);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bn  = 1'b0;
        bp  = 1'b0;
        fs  = 1'b0;
        tick(3);
        rst      = 1'b0;
        m_idx    = 0;
        m_pend   = 0;
        m_settle = 0;
        exp_q.delete();
    endtask

    // Hold buttons, release, and allow the release to debounce
    task automatic press(input bit nx, input bit pv, input int hold);
        bn = nx;
        bp = pv;
        tick(hold);
        bn = 1'b0;
        bp = 1'b0;
        tick(12);
        if (hold >= int'(DB) && (nx ^ pv) && m_pend == 0 && m_settle == 0)
            m_pend = nx ? 1 : -1;
    endtask

    task automatic frame();
        fs = 1'b1;
        if (m_pend != 0) begin
            m_idx = (m_idx + m_pend + NS) % NS;
            exp_q.push_back(onehot(m_idx));
            m_pend   = 0;
            m_settle = int'(SF);
        end else if (m_settle > 0) begin
            m_settle--;
        end
        tick(1);
        fs = 1'b0;
        tick(3);
    endtask

    task automatic check_model(input string tag);
        check({tag, "_state"}, 32'(st), 32'(onehot(m_idx)));
        check({tag, "_busy"}, 32'(busy), 32'((m_pend != 0) || (m_settle > 0)));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, time %0t expected below 2000000", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values and basic next
        do_reset();
        check("reset_state", 32'(st), 32'h1);
        check("reset_switch", 32'(sw), 32'h0);
        check("reset_busy", 32'(busy), 32'h0);
        press(1'b1, 1'b0, 10);
        check("t1_busy_pending", 32'(busy), 32'h1);
        check("t1_state_held", 32'(st), 32'h1);
        frame();
        check_model("t1");
        check("t1_drained", 32'(exp_q.size()), 32'h0);

        // Bounces shorter than the debounce window
        do_reset();
        for (int i = 0; i < 5; i++) begin
            bn = 1'b1;
            tick(3);
            bn = 1'b0;
            tick(3);
        end
        tick(10);
        check("t2_busy", 32'(busy), 32'h0);
        frame();
        check("t2_state", 32'(st), 32'h1);

        // Wrap in both directions
        do_reset();
        press(1'b0, 1'b1, 10);
        frame();
        check("t3_prev_wrap", 32'(st), 32'h8);
        frame();
        check_model("t3_settled");
        press(1'b1, 1'b0, 10);
        frame();
        check("t3_next_wrap", 32'(st), 32'h1);

        // Simultaneous next and prev
        do_reset();
        press(1'b1, 1'b1, 10);
        check("t4_busy", 32'(busy), 32'h0);
        frame();
        frame();
        frame();
        check("t4_state", 32'(st), 32'h1);

        // Request during SETTLE is dropped
        do_reset();
        press(1'b1, 1'b0, 10);
        frame();
        press(1'b1, 1'b0, 10);
        check("t5_busy_settle", 32'(busy), 32'h1);
        frame();
        check("t5_busy_idle", 32'(busy), 32'h0);
        frame();
        check("t5_state", 32'(st), 32'h2);
        check_model("t5");

        // Idle period followed by a frame start
        do_reset();
        tick(40);
`ifdef DEMO_SEQ_AUTO_EN
        m_pend = 1;
`endif
        frame();
        check_model("t6");

        // Random traffic against the model
        do_reset();
        for (int i = 0; i < 30; i++) begin
            int act;
            act = int'($urandom_range(0, 5));
            case (act)
                0: press(1'b1, 1'b0, int'($urandom_range(2, 10)));
                1: press(1'b0, 1'b1, int'($urandom_range(2, 10)));
                2: press(1'b1, 1'b1, int'($urandom_range(2, 10)));
                5: press($urandom_range(0, 1) == 1, 1'b0, int'($urandom_range(1, 3)));
                default: frame();
            endcase
            check_model("rnd");
        end

        tick(4);
        check("final_drained", 32'(exp_q.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
